vga_sync_gen: RTL and testbench

- Generates VGA 640x480@60 Hz raster timing for the ping-pong renderer, directly upstream of it.
- Outputs registered active-low hsync/vsync, the current pixel coordinate, a video_on blanking flag, and tick strobes.
- The renderer uses pixel_x/pixel_y/video_on to compute rgb; hsync/vsync go straight to the board pins.

---
 rtl/vga_timing_pkg.sv | 20 ++
 rtl/pixel_tick_gen.sv | 38 +++
 rtl/vga_sync_gen.sv | 121 ++++++++++++
 tb/tb_vga_sync_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 Hz timing constants and the pixel coordinate type shared with the renderer.
package vga_timing_pkg;

  localparam int unsigned H_DISP_DEF = 640;
  localparam int unsigned H_FP_DEF   = 16;
  localparam int unsigned H_SYNC_DEF = 96;
  localparam int unsigned H_BP_DEF   = 48;
  localparam int unsigned V_DISP_DEF = 480;
  localparam int unsigned V_FP_DEF   = 10;
  localparam int unsigned V_SYNC_DEF = 2;
  localparam int unsigned V_BP_DEF   = 33;

  localparam int unsigned H_TOTAL_DEF = H_DISP_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_DISP_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned CNT_W_DEF = 10;

  typedef logic [CNT_W_DEF-1:0] pixel_coord_t;

endpackage

// File: rtl/pixel_tick_gen.sv
// Clock divider producing a registered one-clk pixel strobe every DIV system clocks.
module pixel_tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_p_tick
);

  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("pixel_tick_gen: DIV must be >= 1");
  end

  logic [DivW-1:0] r_div;
  logic [DivW-1:0] w_div_next;
  logic            r_p_tick;

  always_comb begin
    w_div_next = (r_div == DivMax) ? '0 : r_div + DivW'(1);
  end

  // Strobe is registered from the next divider value so it lines up with divider==DIV-1.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_div    <= '0;
      r_p_tick <= 1'b0;
    end else begin
      r_div    <= w_div_next;
      r_p_tick <= (w_div_next == DivMax);
    end
  end

  assign o_p_tick = r_p_tick;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel counters, registered active-low syncs, blanking and frame strobes.
// Build option: define VGA_SYNC_FRAME_CNT_EN to enable the 8-bit frame counter on o_frame_cnt.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned DIV    = 2,
  parameter int unsigned H_DISP = H_DISP_DEF,
  parameter int unsigned H_FP   = H_FP_DEF,
  parameter int unsigned H_SYNC = H_SYNC_DEF,
  parameter int unsigned H_BP   = H_BP_DEF,
  parameter int unsigned V_DISP = V_DISP_DEF,
  parameter int unsigned V_FP   = V_FP_DEF,
  parameter int unsigned V_SYNC = V_SYNC_DEF,
  parameter int unsigned V_BP   = V_BP_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_video_on,
  output logic             o_p_tick,
  output logic             o_frame_tick,
  output logic [CNT_W-1:0] o_pixel_x,
  output logic [CNT_W-1:0] o_pixel_y,
  output logic [7:0]       o_frame_cnt
);

  localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  if ((H_TOTAL > (1 << CNT_W)) || (V_TOTAL > (1 << CNT_W))) begin : g_bad_cnt_w
    $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] HMax      = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VMax      = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HDisp     = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] VDisp     = CNT_W'(V_DISP);
  localparam logic [CNT_W-1:0] HSyncBeg  = CNT_W'(H_DISP + H_FP);
  localparam logic [CNT_W-1:0] HSyncEnd  = CNT_W'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VSyncBeg  = CNT_W'(V_DISP + V_FP);
  localparam logic [CNT_W-1:0] VSyncEnd  = CNT_W'(V_DISP + V_FP + V_SYNC - 1);

  logic             w_p_tick;
  logic             w_x_wrap;
  logic             w_y_wrap;
  logic             w_frame_tick;
  logic [CNT_W-1:0] w_x_next;
  logic [CNT_W-1:0] w_y_next;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;

  pixel_tick_gen #(
    .DIV(DIV)
  ) u_pixel_tick_gen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_p_tick(w_p_tick)
  );

  always_comb begin
    w_x_wrap = (r_x == HMax);
    w_y_wrap = (r_y == VMax);
    w_x_next = r_x;
    w_y_next = r_y;
    if (w_p_tick) begin
      w_x_next = w_x_wrap ? '0 : r_x + CNT_W'(1);
      if (w_x_wrap) begin
        w_y_next = w_y_wrap ? '0 : r_y + CNT_W'(1);
      end
    end
  end

  // Sync/blank decode from next-state counters keeps them aligned with the registered coordinates.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_x        <= '0;
      r_y        <= '0;
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_video_on <= 1'b1;
    end else begin
      r_x        <= w_x_next;
      r_y        <= w_y_next;
      r_hsync    <= !((w_x_next >= HSyncBeg) && (w_x_next <= HSyncEnd));
      r_vsync    <= !((w_y_next >= VSyncBeg) && (w_y_next <= VSyncEnd));
      r_video_on <= (w_x_next < HDisp) && (w_y_next < VDisp);
    end
  end

  assign w_frame_tick = w_p_tick && w_x_wrap && w_y_wrap;

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_frame_cnt <= 8'd0;
    end else if (w_frame_tick) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`else
  assign o_frame_cnt = 8'd0;
`endif

  assign o_hsync      = r_hsync;
  assign o_vsync      = r_vsync;
  assign o_video_on   = r_video_on;
  assign o_p_tick     = w_p_tick;
  assign o_frame_tick = w_frame_tick;
  assign o_pixel_x    = r_x;
  assign o_pixel_y    = r_y;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default-timing instance for divider/line/reset checks, tiny-timing instance for frames.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_def, rst_sm;
  logic       hs_d, vs_d, vo_d, pt_d, ft_d;
  logic [9:0] x_d, y_d;
  logic [7:0] fc_d;
  logic       hs_s, vs_s, vo_s, pt_s, ft_s;
  logic [3:0] x_s, y_s;
  logic [7:0] fc_s;

  int n_cmp = 0;
  int n_fail = 0;

  vga_sync_gen u_dut_def (
    .i_clk       (clk),
    .i_reset     (rst_def),
    .o_hsync     (hs_d),
    .o_vsync     (vs_d),
    .o_video_on  (vo_d),
    .o_p_tick    (pt_d),
    .o_frame_tick(ft_d),
    .o_pixel_x   (x_d),
    .o_pixel_y   (y_d),
    .o_frame_cnt (fc_d)
  );

  vga_sync_gen #(
    .DIV(1), .H_DISP(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_DISP(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .CNT_W(4)
  ) u_dut_sm (
    .i_clk       (clk),
    .i_reset     (rst_sm),
    .o_hsync     (hs_s),
    .o_vsync     (vs_s),
    .o_video_on  (vo_s),
    .o_p_tick    (pt_s),
    .o_frame_tick(ft_s),
    .o_pixel_x   (x_s),
    .o_pixel_y   (y_s),
    .o_frame_cnt (fc_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int lines, plen, hs_lo, hs_first, hs_last, vo_lo, vo_first, vo_last, vs_lo;
    int ex, ey, ticks, last_ft;
    bit found;

    rst_def = 1'b0;
    rst_sm  = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_p_tick", pt_d, 0);
    check("rst_x", x_d, 0);
    check("rst_y", y_d, 0);
    check("rst_hsync", hs_d, 1);
    check("rst_vsync", vs_d, 1);
    check("rst_video_on", vo_d, 1);
    check("rst_frame_tick", ft_d, 0);
    check("rst_frame_cnt", fc_d, 0);
    check("rst_sm_p_tick", pt_s, 0);
    check("rst_sm_x", x_s, 0);

    // Divider: DIV=2 strobe every other clk, x advancing one per strobe.
    rst_def = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("div2_p_tick", pt_d, (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) check("div2_x_seq", x_d, i / 2);
    end

    // One full line at default timing, sampled on p_tick cycles.
    lines = 0; plen = 0; hs_lo = 0; hs_first = -1; hs_last = -1;
    vo_lo = 0; vo_first = -1; vo_last = -1; vs_lo = 0;
    for (int c = 0; c < 4000 && lines < 2; c++) begin
      @(negedge clk);
      if (pt_d) begin
        if (x_d == 10'd0) lines++;
        if (lines == 1) begin
          plen++;
          if (!hs_d) begin
            hs_lo++;
            if (hs_first < 0) hs_first = int'(x_d);
            hs_last = int'(x_d);
          end
          if (!vo_d) begin
            vo_lo++;
            if (vo_first < 0) vo_first = int'(x_d);
            vo_last = int'(x_d);
          end
          if (!vs_d) vs_lo++;
        end
      end
    end
    check("line_found", lines, 2);
    check("line_len", plen, 800);
    check("hsync_width", hs_lo, 96);
    check("hsync_first_x", hs_first, 656);
    check("hsync_last_x", hs_last, 751);
    check("blank_width", vo_lo, 160);
    check("blank_first_x", vo_first, 640);
    check("blank_last_x", vo_last, 799);
    check("vsync_idle_line", vs_lo, 0);
    check("y_after_line", y_d, 2);

    // Mid-line reset while hsync is low.
    found = 0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge clk);
      if (pt_d && x_d == 10'd700) found = 1;
    end
    check("reach_x700", found, 1);
    check("x700_hsync", hs_d, 0);
    rst_def = 1'b0;
    @(negedge clk);
    check("midrst_hsync", hs_d, 1);
    check("midrst_vsync", vs_d, 1);
    check("midrst_x", x_d, 0);
    check("midrst_y", y_d, 0);
    check("midrst_frame_tick", ft_d, 0);
    check("midrst_p_tick", pt_d, 0);
    rst_def = 1'b1;

    // Tiny timing: H 8 total (sync x 5..6), V 6 total (sync y 4), DIV=1.
    rst_sm = 1'b1;
    ticks = 0;
    last_ft = -1;
    for (int k = 0; k <= 257 * 48; k++) begin
      @(negedge clk);
      ex = k % 8;
      ey = (k / 8) % 6;
      if (k < 144) begin
        check("sm_p_tick", pt_s, 1);
        check("sm_x", x_s, ex);
        check("sm_y", y_s, ey);
        check("sm_hsync", hs_s, (ex >= 5 && ex <= 6) ? 0 : 1);
        check("sm_vsync", vs_s, (ey == 4) ? 0 : 1);
        check("sm_video_on", vo_s, (ex < 4 && ey < 3) ? 1 : 0);
        check("sm_frame_tick", ft_s, (ex == 7 && ey == 5) ? 1 : 0);
      end
      if (ft_s) begin
        ticks++;
        if (last_ft >= 0) check("sm_frame_period", k - last_ft, 48);
        last_ft = k;
      end
      if (k % 48 == 0) begin
`ifdef VGA_SYNC_FRAME_CNT_EN
        check("sm_frame_cnt", fc_s, (k / 48) % 256);
`else
        check("sm_frame_cnt_off", fc_s, 0);
`endif
      end
    end
    check("sm_frame_ticks", ticks, 257);

    // Mid-frame reset with both syncs low.
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (x_s == 4'd5 && y_s == 4'd4) found = 1;
    end
    check("sm_reach_sync", found, 1);
    check("sm_pre_hsync", hs_s, 0);
    check("sm_pre_vsync", vs_s, 0);
    rst_sm = 1'b0;
    @(negedge clk);
    check("sm_midrst_hsync", hs_s, 1);
    check("sm_midrst_vsync", vs_s, 1);
    check("sm_midrst_x", x_s, 0);
    check("sm_midrst_y", y_s, 0);
    check("sm_midrst_frame_tick", ft_s, 0);
    check("sm_midrst_frame_cnt", fc_s, 0);
    rst_sm = 1'b1;
    @(negedge clk);
    check("sm_post_p_tick", pt_s, 1);
    check("sm_post_x", x_s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
